ma_stage: RTL and testbench

- Memory-access pipeline stage, directly downstream of the execute stage and upstream of write-back.
- Registers the execute-to-memory bus under a valid/allowin handshake.
- Selects the final result: the data-SRAM read word for loads, the ALU result otherwise.
- Drives a forwarding bus back to decode. Holds the one-cycle-lived SRAM read data in a capture buffer when write-back stalls.

---
 rtl/ma_stage_pkg.sv | 24 ++
 rtl/ma_rdata_hold.sv | 57 +++++
 rtl/ma_stage.sv | 81 ++++++++
 tb/tb_ma_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ma_stage_pkg.sv
// Shared widths and field offsets for the execute -> memory -> write-back buses.
package ma_stage_pkg;

    localparam int unsigned EX_MA_BUS_WIDTH = 71;
    localparam int unsigned MA_WB_BUS_WIDTH = 70;
    localparam int unsigned MA_ID_BUS_WIDTH = 38;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned DEST_W = 5;

    // ex_to_ma_bus: {res_from_mem, gr_we, dest, alu_result, pc}
    localparam int unsigned EX_RES_FROM_MEM_BIT = 70;
    localparam int unsigned EX_GR_WE_BIT        = 69;
    localparam int unsigned EX_DEST_LSB         = 64;
    localparam int unsigned EX_ALU_RESULT_LSB   = 32;
    localparam int unsigned EX_PC_LSB           = 0;

    // ma_to_wb_bus: {gr_we, dest, final_result, pc}
    localparam int unsigned WB_GR_WE_BIT        = 69;
    localparam int unsigned WB_DEST_LSB         = 64;
    localparam int unsigned WB_RESULT_LSB       = 32;
    localparam int unsigned WB_PC_LSB           = 0;

endpackage

// File: rtl/ma_rdata_hold.sv
// Holds the one-cycle-lived SRAM read word across write-back stalls and
// selects the final result for the memory stage.
module ma_rdata_hold
    import ma_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              valid,
    input  logic              wb_allowin,
    input  logic              res_from_mem,
    input  logic [WORD_W-1:0] alu_result,
    input  logic [WORD_W-1:0] data_sram_rdata,
    output logic [WORD_W-1:0] final_result
);

    logic              first_cyc_q;
    logic [WORD_W-1:0] rbuf_q;
    logic              rbuf_vld_q;
    logic              capture;
    logic              rbuf_clr;

    // SRAM data is only live in the first cycle; grab it if we cannot leave yet.
    assign capture  = valid & first_cyc_q & res_from_mem & ~wb_allowin;
    assign rbuf_clr = (valid & wb_allowin) | accept;

    // Mark the first cycle an instruction spends in this stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_cyc_q <= 1'b0;
        end else begin
            first_cyc_q <= accept;
        end
    end

    // Capture buffer and its valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbuf_q     <= '0;
            rbuf_vld_q <= 1'b0;
        end else if (capture) begin
            rbuf_q     <= data_sram_rdata;
            rbuf_vld_q <= 1'b1;
        end else if (rbuf_clr) begin
            rbuf_vld_q <= 1'b0;
        end
    end

    // Result mux: buffered word, live SRAM word, or ALU result.
    always_comb begin
        final_result = alu_result;
        if (res_from_mem) begin
            final_result = rbuf_vld_q ? rbuf_q : data_sram_rdata;
        end
    end

endmodule

// File: rtl/ma_stage.sv
// Memory-access pipeline stage: registers the execute bus, picks the final
// result and drives the forwarding bus back to decode.
module ma_stage
    import ma_stage_pkg::*;
#(
    parameter int unsigned EX_MA_BUS_W = EX_MA_BUS_WIDTH,
    parameter int unsigned MA_WB_BUS_W = MA_WB_BUS_WIDTH,
    parameter int unsigned MA_ID_BUS_W = MA_ID_BUS_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_validout,
    input  logic                   wb_allowin,
    output logic                   ma_allowin,
    output logic                   ma_validout,
    input  logic [EX_MA_BUS_W-1:0] ex_to_ma_bus,
    input  logic [WORD_W-1:0]      data_sram_rdata,
    output logic [MA_WB_BUS_W-1:0] ma_to_wb_bus,
    output logic [MA_ID_BUS_W-1:0] ma_to_id_bus
);

    logic                   valid_q;
    logic [EX_MA_BUS_W-1:0] bus_q;
    logic                   accept;
    logic                   res_from_mem;
    logic                   gr_we;
    logic [DEST_W-1:0]      dest;
    logic [WORD_W-1:0]      alu_result;
    logic [WORD_W-1:0]      pc;
    logic [WORD_W-1:0]      final_result;

    // This stage always completes in one cycle, so only write-back can stall it.
    assign ma_allowin  = ~valid_q | wb_allowin;
    assign ma_validout = valid_q;
    assign accept      = ex_validout & ma_allowin;

    assign res_from_mem = bus_q[EX_RES_FROM_MEM_BIT];
    assign gr_we        = bus_q[EX_GR_WE_BIT];
    assign dest         = bus_q[EX_DEST_LSB +: DEST_W];
    assign alu_result   = bus_q[EX_ALU_RESULT_LSB +: WORD_W];
    assign pc           = bus_q[EX_PC_LSB +: WORD_W];

    // Stage occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (ma_allowin) begin
            valid_q <= ex_validout;
        end
    end

    // Instruction payload, loaded only on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_q <= '0;
        end else if (accept) begin
            bus_q <= ex_to_ma_bus;
        end
    end

    ma_rdata_hold u_rdata_hold (
        .clk             (clk),
        .rst             (rst),
        .accept          (accept),
        .valid           (valid_q),
        .wb_allowin      (wb_allowin),
        .res_from_mem    (res_from_mem),
        .alu_result      (alu_result),
        .data_sram_rdata (data_sram_rdata),
        .final_result    (final_result)
    );

    // Outgoing buses; a zero forwarding dest means "no producer" to decode.
    always_comb begin
        ma_to_wb_bus = {gr_we, dest, final_result, pc};
        ma_to_id_bus = {valid_q & res_from_mem,
                        dest & {DEST_W{valid_q & gr_we}},
                        final_result};
    end

endmodule

// File: tb/tb_ma_stage.sv
// Directed self-checking bench for ma_stage.
module tb_ma_stage;

    logic        clk;
    logic        rst;
    logic        ex_validout;
    logic        wb_allowin;
    logic        ma_allowin;
    logic        ma_validout;
    logic [70:0] ex_to_ma_bus;
    logic [31:0] data_sram_rdata;
    logic [69:0] ma_to_wb_bus;
    logic [37:0] ma_to_id_bus;

    int checks = 0;
    int errors = 0;

    ma_stage dut (
        .clk             (clk),
        .rst             (rst),
        .ex_validout     (ex_validout),
        .wb_allowin      (wb_allowin),
        .ma_allowin      (ma_allowin),
        .ma_validout     (ma_validout),
        .ex_to_ma_bus    (ex_to_ma_bus),
        .data_sram_rdata (data_sram_rdata),
        .ma_to_wb_bus    (ma_to_wb_bus),
        .ma_to_id_bus    (ma_to_id_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and let outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [70:0] mk(input logic rfm, input logic we, input logic [4:0] d,
                                       input logic [31:0] alu, input logic [31:0] pc);
        return {rfm, we, d, alu, pc};
    endfunction

    logic [70:0] stream [3];

    initial begin
        rst             = 1'b1;
        ex_validout     = 1'b0;
        wb_allowin      = 1'b1;
        ex_to_ma_bus    = '0;
        data_sram_rdata = '0;
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_validout", 70'(ma_validout), 70'(0));
        check("rst_allowin", 70'(ma_allowin), 70'(1));
        check("rst_id_bus", 70'(ma_to_id_bus), 70'(0));
        check("rst_wb_bus", ma_to_wb_bus, 70'(0));
        step();
        step();
        check("idle_validout", 70'(ma_validout), 70'(0));
        check("idle_id_bus", 70'(ma_to_id_bus), 70'(0));

        // ALU pass-through
        ex_to_ma_bus = mk(1'b0, 1'b1, 5'd5, 32'h12345678, 32'h1C000000);
        ex_validout  = 1'b1;
        step();
        ex_validout = 1'b0;
        #1;
        check("alu_validout", 70'(ma_validout), 70'(1));
        check("alu_wb_bus", ma_to_wb_bus, {1'b1, 5'd5, 32'h12345678, 32'h1C000000});
        check("alu_id_bus", 70'(ma_to_id_bus), 70'({1'b0, 5'd5, 32'h12345678}));
        step();
        check("alu_after_validout", 70'(ma_validout), 70'(0));
        check("alu_after_fwd_dest", 70'(ma_to_id_bus[36:32]), 70'(0));

        // Load, no stall
        ex_to_ma_bus = mk(1'b1, 1'b1, 5'd3, 32'h00000100, 32'h1C000004);
        ex_validout  = 1'b1;
        step();
        ex_validout     = 1'b0;
        data_sram_rdata = 32'hDEADBEEF;
        #1;
        check("ld_result", 70'(ma_to_wb_bus[63:32]), 70'(32'hDEADBEEF));
        check("ld_id_bus", 70'(ma_to_id_bus), 70'({1'b1, 5'd3, 32'hDEADBEEF}));
        step();
        data_sram_rdata = 32'h0;
        check("ld_leave_validout", 70'(ma_validout), 70'(0));

        // Load with a 3-cycle stall; a different ALU op waits upstream meanwhile
        ex_to_ma_bus = mk(1'b1, 1'b1, 5'd4, 32'h00000200, 32'h1C000008);
        ex_validout  = 1'b1;
        step();
        ex_to_ma_bus    = mk(1'b0, 1'b1, 5'd9, 32'hA5A5A5A5, 32'h1C00000C);
        wb_allowin      = 1'b0;
        data_sram_rdata = 32'hCAFEF00D;
        #1;
        check("stall1_result", 70'(ma_to_wb_bus[63:32]), 70'(32'hCAFEF00D));
        check("stall1_allowin", 70'(ma_allowin), 70'(0));
        step();
        data_sram_rdata = 32'h0;
        #1;
        check("stall2_result", 70'(ma_to_wb_bus[63:32]), 70'(32'hCAFEF00D));
        check("stall2_allowin", 70'(ma_allowin), 70'(0));
        check("stall2_pc", 70'(ma_to_wb_bus[31:0]), 70'(32'h1C000008));
        step();
        check("stall3_result", 70'(ma_to_wb_bus[63:32]), 70'(32'hCAFEF00D));
        check("stall3_validout", 70'(ma_validout), 70'(1));
        check("stall3_id_bus", 70'(ma_to_id_bus), 70'({1'b1, 5'd4, 32'hCAFEF00D}));
        wb_allowin = 1'b1;
        #1;
        check("unstall_allowin", 70'(ma_allowin), 70'(1));
        step();
        // Leave and enter on the same edge
        ex_validout = 1'b0;
        #1;
        check("swap_validout", 70'(ma_validout), 70'(1));
        check("swap_wb_bus", ma_to_wb_bus, {1'b1, 5'd9, 32'hA5A5A5A5, 32'h1C00000C});
        step();

        // Back-to-back stream then bubble
        stream[0] = mk(1'b0, 1'b1, 5'd1, 32'h11111111, 32'h1C000100);
        stream[1] = mk(1'b0, 1'b1, 5'd2, 32'h22222222, 32'h1C000104);
        stream[2] = mk(1'b0, 1'b1, 5'd3, 32'h33333333, 32'h1C000108);
        ex_validout = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex_to_ma_bus = stream[i];
            step();
            check($sformatf("b2b%0d_validout", i), 70'(ma_validout), 70'(1));
            check($sformatf("b2b%0d_wb_bus", i), ma_to_wb_bus, stream[i][69:0]);
        end
        ex_validout = 1'b0;
        step();
        check("bubble_validout", 70'(ma_validout), 70'(0));
        check("bubble_fwd_dest", 70'(ma_to_id_bus[36:32]), 70'(0));
        check("bubble_fwd_load", 70'(ma_to_id_bus[37]), 70'(0));

        // Store (gr_we=0), also held over a non-load stall
        ex_to_ma_bus = mk(1'b0, 1'b0, 5'd7, 32'h0000BEEF, 32'h1C000200);
        ex_validout  = 1'b1;
        step();
        ex_validout     = 1'b0;
        wb_allowin      = 1'b0;
        data_sram_rdata = 32'h77777777;
        #1;
        check("st_fwd_dest", 70'(ma_to_id_bus[36:32]), 70'(0));
        check("st_gr_we", 70'(ma_to_wb_bus[69]), 70'(0));
        check("st_dest", 70'(ma_to_wb_bus[68:64]), 70'(7));
        step();
        check("st_stall_result", 70'(ma_to_wb_bus[63:32]), 70'(32'h0000BEEF));
        wb_allowin = 1'b1;
        step();
        check("st_leave_validout", 70'(ma_validout), 70'(0));

        // Reset while a load is stalled with its data buffered
        ex_to_ma_bus = mk(1'b1, 1'b1, 5'd6, 32'h00000300, 32'h1C000300);
        ex_validout  = 1'b1;
        step();
        ex_validout     = 1'b0;
        wb_allowin      = 1'b0;
        data_sram_rdata = 32'h55AA55AA;
        step();
        data_sram_rdata = 32'h0;
        #1;
        check("pre_rst_result", 70'(ma_to_wb_bus[63:32]), 70'(32'h55AA55AA));
        #1;
        rst = 1'b1;
        #1;
        check("arst_validout", 70'(ma_validout), 70'(0));
        check("arst_allowin", 70'(ma_allowin), 70'(1));
        check("arst_id_bus", 70'(ma_to_id_bus), 70'(0));
        check("arst_wb_bus", ma_to_wb_bus, 70'(0));
        step();
        rst        = 1'b0;
        wb_allowin = 1'b1;
        step();
        check("post_rst_validout", 70'(ma_validout), 70'(0));
        check("post_rst_id_bus", 70'(ma_to_id_bus), 70'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
